// File: rtl/router_input_channel.sv
// router_input_channel: one mesh-router input port.
// Incoming flits are buffered in NUM_VC virtual-channel FIFOs selected by a
// rotating phase counter. The head of the VC being offered is routed
// dimension-ordered and presented with the relevant hop count decremented.
// Optional build macro: ROUTER_IC_YFIRST_EN selects Y-first routing
// (default, macro undefined: X-first routing).
module router_input_channel #(
  parameter int DATA_W = 64,
  parameter int NUM_VC = 2,
  parameter int DEPTH  = 4,
  parameter int HOP_W  = 4,
  parameter int PL_W   = 48,
  localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_si,
  input  logic [DATA_W-1:0]       in_di,
  output logic                    in_ri,
  output logic [VC_W-1:0]         phase,
  output logic                    out_vld,
  output logic [2:0]              out_dir,
  output logic [VC_W-1:0]         out_vc,
  output logic [DATA_W-1:0]       out_do,
  input  logic                    out_gnt,
  output logic [NUM_VC*CNT_W-1:0] occ,
  output logic                    err_vc
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int XDIR_B = DATA_W - 1 - VC_W;
  localparam int YDIR_B = DATA_W - 2 - VC_W;
  localparam int HX_LO  = PL_W + HOP_W;
  localparam int HY_LO  = PL_W;
  localparam logic [VC_W-1:0]  LAST_VC   = VC_W'(NUM_VC - 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [2:0]       DIR_UP    = 3'd0;
  localparam logic [2:0]       DIR_DOWN  = 3'd1;
  localparam logic [2:0]       DIR_LEFT  = 3'd2;
  localparam logic [2:0]       DIR_RIGHT = 3'd3;
  localparam logic [2:0]       DIR_NIC   = 3'd4;

  logic [VC_W-1:0]   phase_reg;
  logic [VC_W-1:0]   rd_vc;
  logic [NUM_VC-1:0] full;
  logic [NUM_VC-1:0] empty;
  logic [DATA_W-1:0] head [NUM_VC];
  logic [DATA_W-1:0] head_sel;
  logic              wr_en;
  logic              pop;
  logic              vc_match;
  logic              err_reg;
  logic [2:0]        route_dir;
  logic [DATA_W-1:0] route_flit;
  logic [HOP_W-1:0]  hop_x;
  logic [HOP_W-1:0]  hop_y;

  // Pointer advance with explicit wrap so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // The VC being read is always one ahead of the VC being written, so a
  // FIFO is never written and read in the same cycle.
  assign rd_vc    = (phase_reg == LAST_VC) ? '0 : phase_reg + VC_W'(1);
  assign vc_match = (in_di[DATA_W-1 -: VC_W] == phase_reg);
  assign in_ri    = !reset && !full[phase_reg];
  assign wr_en    = in_si && in_ri && vc_match;
  assign out_vld  = !reset && !empty[rd_vc];
  assign pop      = out_vld && out_gnt;
  assign head_sel = head[rd_vc];
  assign phase    = phase_reg;
  assign out_vc   = rd_vc;
  assign err_vc   = err_reg;

  // Phase rotates through every VC once per NUM_VC cycles.
  always_ff @(posedge clk) begin
    if (reset) phase_reg <= '0;
    else       phase_reg <= (phase_reg == LAST_VC) ? '0 : phase_reg + VC_W'(1);
  end

  // Sticky flag for a flit offered on a VC other than the current phase.
  always_ff @(posedge clk) begin
    if (reset)                    err_reg <= 1'b0;
    else if (in_si && !vc_match)  err_reg <= 1'b1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
      logic [DATA_W-1:0] mem [DEPTH];
      logic [PTR_W-1:0]  wr_ptr_reg;
      logic [PTR_W-1:0]  rd_ptr_reg;
      logic [CNT_W-1:0]  count_reg;
      logic              wr_here;
      logic              rd_here;

      assign wr_here = wr_en && (phase_reg == VC_W'(gi));
      assign rd_here = pop && (rd_vc == VC_W'(gi));

      // Flit storage; contents need no reset since the count gates validity.
      always_ff @(posedge clk) begin
        if (wr_here) mem[wr_ptr_reg] <= in_di;
      end

      // Pointer and occupancy bookkeeping for this VC.
      always_ff @(posedge clk) begin
        if (reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (wr_here) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
          if (rd_here) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
          case ({wr_here, rd_here})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
          endcase
        end
      end

      assign full[gi]                = (count_reg == CNT_W'(DEPTH));
      assign empty[gi]               = (count_reg == '0);
      assign head[gi]                = mem[rd_ptr_reg];
      assign occ[gi*CNT_W +: CNT_W]  = count_reg;
    end
  endgenerate

  // Dimension-ordered route of the offered head flit, hop count decremented.
  always_comb begin
    route_dir  = DIR_NIC;
    route_flit = head_sel;
    hop_x      = head_sel[HX_LO +: HOP_W];
    hop_y      = head_sel[HY_LO +: HOP_W];
`ifdef ROUTER_IC_YFIRST_EN
    if (hop_y != '0) begin
      route_dir                  = head_sel[YDIR_B] ? DIR_DOWN : DIR_UP;
      route_flit[HY_LO +: HOP_W] = hop_y - HOP_W'(1);
    end else if (hop_x != '0) begin
      route_dir                  = head_sel[XDIR_B] ? DIR_LEFT : DIR_RIGHT;
      route_flit[HX_LO +: HOP_W] = hop_x - HOP_W'(1);
    end
`else
    if (hop_x != '0) begin
      route_dir                  = head_sel[XDIR_B] ? DIR_LEFT : DIR_RIGHT;
      route_flit[HX_LO +: HOP_W] = hop_x - HOP_W'(1);
    end else if (hop_y != '0) begin
      route_dir                  = head_sel[YDIR_B] ? DIR_DOWN : DIR_UP;
      route_flit[HY_LO +: HOP_W] = hop_y - HOP_W'(1);
    end
`endif
  end

  // Outputs are forced to zero whenever nothing is being offered.
  always_comb begin
    out_dir = out_vld ? route_dir : 3'd0;
    out_do  = out_vld ? route_flit : '0;
  end

endmodule
